// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl -- receive-side controller between a UART receiver and a host.
//
// Watches the receiver's frame-done / error levels, pushes each received byte
// into a small FIFO exactly once per done pulse, and holds the receiver
// disabled for RECOVER_CYCLES cycles after every error edge.
//
// Optional statistics: define UART_RX_CTRL_STATS_EN to build the overrun
// flag and the saturating err_count. When it is undefined both outputs are
// tied to 0 and stat_clr is ignored.
//
// Ports:
//   rx_clock       in   clock, rising edge
//   rx_reset       in   synchronous active-high reset
//   ctrl_enable    in   host enable (0 = receiver disabled)
//   rx_done_in     in   receiver frame-done level
//   rx_error_in    in   receiver error level
//   rx_data_in     in   received byte, valid while rx_done_in=1
//   rx_enable_out  out  receiver enable (registered)
//   rd_en          in   host pop request
//   rd_data        out  popped byte (registered, holds when no pop)
//   rd_valid       out  one-cycle strobe qualifying rd_data
//   fifo_empty     out  FIFO empty (registered)
//   fifo_full      out  FIFO full (registered)
//   overrun        out  sticky: byte dropped on full FIFO
//   stat_clr       in   clears overrun and err_count
//   err_count      out  saturating receiver error count
module uart_rx_ctrl #(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned RECOVER_CYCLES = 64
) (
    input  logic       rx_clock,
    input  logic       rx_reset,
    input  logic       ctrl_enable,
    input  logic       rx_done_in,
    input  logic       rx_error_in,
    input  logic [7:0] rx_data_in,
    output logic       rx_enable_out,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       fifo_empty,
    output logic       fifo_full,
    output logic       overrun,
    input  logic       stat_clr,
    output logic [7:0] err_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {DISABLED, ARMED, CAPTURE, RECOVER} state_t;

    state_t          state_q;
    logic            done_q;
    logic            err_q;
    logic            en_q;
    logic [7:0]      rec_cnt_q;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            empty_q;
    logic            full_q;
    logic [7:0]      rd_data_q;
    logic            rd_valid_q;

    logic            done_rise;
    logic            err_rise;
    logic            push_req;
    logic            err_evt;
    logic            pop;
    logic            full_now;
    logic            do_push;
    logic            ov_set;

    always_comb begin
        done_rise = rx_done_in & ~done_q;
        err_rise  = rx_error_in & ~err_q;
        // Error edge wins over a simultaneous done edge.
        err_evt   = (state_q == ARMED) && ctrl_enable && err_rise;
        push_req  = (state_q == ARMED) && ctrl_enable && !err_rise
                    && done_rise && !rx_error_in;
        pop       = rd_en && (count_q != '0);
        full_now  = (count_q == CW'(FIFO_DEPTH));
        // A pop in the same cycle frees the slot before the push lands.
        do_push   = push_req && (!full_now || pop);
        ov_set    = push_req && full_now && !pop;
        count_d   = count_q + CW'(do_push) - CW'(pop);
    end

    // Control FSM; rx_enable_out is registered alongside the state.
    always_ff @(posedge rx_clock) begin
        if (rx_reset) begin
            state_q   <= DISABLED;
            en_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rec_cnt_q <= '0;
        end else begin
            done_q <= rx_done_in;
            err_q  <= rx_error_in;
            if (!ctrl_enable) begin
                state_q   <= DISABLED;
                en_q      <= 1'b0;
                rec_cnt_q <= '0;
            end else begin
                case (state_q)
                    DISABLED: begin
                        state_q <= ARMED;
                        en_q    <= 1'b1;
                    end
                    ARMED: begin
                        if (err_rise) begin
                            state_q   <= RECOVER;
                            en_q      <= 1'b0;
                            rec_cnt_q <= '0;
                        end else if (done_rise && !rx_error_in) begin
                            state_q <= CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        if (!rx_done_in) state_q <= ARMED;
                    end
                    RECOVER: begin
                        if (rec_cnt_q == 8'(RECOVER_CYCLES - 1)) begin
                            state_q <= ARMED;
                            en_q    <= 1'b1;
                        end else begin
                            rec_cnt_q <= rec_cnt_q + 8'd1;
                        end
                    end
                    default: begin
                        state_q <= DISABLED;
                        en_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge rx_clock) begin
        if (do_push && !rx_reset) mem_q[wr_ptr_q] <= rx_data_in;
    end

    always_ff @(posedge rx_clock) begin
        if (rx_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                rd_data_q <= mem_q[rd_ptr_q];
            end
            rd_valid_q <= pop;
            count_q    <= count_d;
            empty_q    <= (count_d == '0);
            full_q     <= (count_d == CW'(FIFO_DEPTH));
        end
    end

`ifdef UART_RX_CTRL_STATS_EN
    logic [7:0] err_cnt_q;
    logic       ov_q;

    // Set events take precedence over a same-cycle stat_clr.
    always_ff @(posedge rx_clock) begin
        if (rx_reset) begin
            err_cnt_q <= '0;
            ov_q      <= 1'b0;
        end else begin
            if (err_evt) begin
                if (stat_clr)                err_cnt_q <= 8'd1;
                else if (err_cnt_q != '1)    err_cnt_q <= err_cnt_q + 8'd1;
            end else if (stat_clr) begin
                err_cnt_q <= '0;
            end
            if (ov_set)        ov_q <= 1'b1;
            else if (stat_clr) ov_q <= 1'b0;
        end
    end

    assign err_count = err_cnt_q;
    assign overrun   = ov_q;
`else
    logic unused_stats;
    assign unused_stats = stat_clr ^ ov_set ^ err_evt;
    assign err_count    = '0;
    assign overrun      = 1'b0;
`endif

    assign rx_enable_out = en_q;
    assign rd_data       = rd_data_q;
    assign rd_valid      = rd_valid_q;
    assign fifo_empty    = empty_q;
    assign fifo_full     = full_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

    localparam int DEPTH = 8;
    localparam int REC   = 64;
`ifdef UART_RX_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       rx_clock;
    logic       rx_reset;
    logic       ctrl_enable;
    logic       rx_done_in;
    logic       rx_error_in;
    logic [7:0] rx_data_in;
    logic       rx_enable_out;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       fifo_empty;
    logic       fifo_full;
    logic       overrun;
    logic       stat_clr;
    logic [7:0] err_count;

    uart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .RECOVER_CYCLES(REC)) dut (
        .rx_clock      (rx_clock),
        .rx_reset      (rx_reset),
        .ctrl_enable   (ctrl_enable),
        .rx_done_in    (rx_done_in),
        .rx_error_in   (rx_error_in),
        .rx_data_in    (rx_data_in),
        .rx_enable_out (rx_enable_out),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .fifo_empty    (fifo_empty),
        .fifo_full     (fifo_full),
        .overrun       (overrun),
        .stat_clr      (stat_clr),
        .err_count     (err_count)
    );

    initial rx_clock = 1'b0;
    always #5 rx_clock = ~rx_clock;

    int checks = 0;
    int errors = 0;

    // Reference model: byte queue plus statistics.
    logic [7:0] q[$];
    int         model_err = 0;
    bit         model_ov  = 1'b0;
    logic [7:0] last_rd   = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge rx_clock);
        #1;
    endtask

    task automatic model_push(input logic [7:0] b, input bit popping);
        if (q.size() < DEPTH || popping) q.push_back(b);
        else model_ov = 1'b1;
    endtask

    task automatic model_err_evt(input bit clr);
        if (clr) model_err = 1;
        else if (model_err < 255) model_err++;
        if (clr) model_ov = 1'b0;
    endtask

    task automatic check_flags(input string tag);
        check({tag, ".empty"},   fifo_empty, q.size() == 0);
        check({tag, ".full"},    fifo_full,  q.size() == DEPTH);
        check({tag, ".overrun"}, overrun,    STATS ? model_ov : 1'b0);
        check({tag, ".errcnt"},  err_count,  STATS ? model_err : 0);
    endtask

    task automatic send(input logic [7:0] b, input int len);
        rx_data_in = b;
        rx_done_in = 1'b1;
        tick();
        model_push(b, 1'b0);
        repeat (len - 1) tick();
        rx_done_in = 1'b0;
        rx_data_in = 8'($urandom);
        tick();
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] exp;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        if (q.size() > 0) begin
            exp = q.pop_front();
            check({tag, ".valid"}, rd_valid, 1'b1);
            check({tag, ".data"},  rd_data,  exp);
            last_rd = exp;
        end else begin
            check({tag, ".valid_empty"}, rd_valid, 1'b0);
            check({tag, ".data_hold"},   rd_data,  last_rd);
        end
    endtask

    task automatic do_clr();
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        model_err = 0;
        model_ov  = 1'b0;
    endtask

    // Error edge (optionally with a done edge and/or stat_clr in the same
    // cycle), then measure how long the receiver stays disabled.
    task automatic error_event(input string tag, input bit clr, input bit with_done);
        int n;
        rx_error_in = 1'b1;
        rx_done_in  = with_done;
        rx_data_in  = 8'hEE;
        stat_clr    = clr;
        tick();
        stat_clr    = 1'b0;
        rx_error_in = 1'b0;
        rx_done_in  = 1'b0;
        model_err_evt(clr);
        n = 0;
        while (rx_enable_out === 1'b0 && n < 300) begin
            n++;
            tick();
        end
        check({tag, ".recover_len"}, n, REC);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp;
        rx_reset = 1'b1; ctrl_enable = 1'b0; rx_done_in = 1'b0; rx_error_in = 1'b0;
        rx_data_in = 8'h00; rd_en = 1'b0; stat_clr = 1'b0;
        repeat (3) tick();
        check("rst.enable", rx_enable_out, 1'b0);
        check("rst.rd_data", rd_data, 8'h00);
        check("rst.rd_valid", rd_valid, 1'b0);
        check_flags("rst");

        rx_reset = 1'b0;
        ctrl_enable = 1'b1;
        tick();
        check("armed.enable", rx_enable_out, 1'b1);

        // Long done pulse -> exactly one byte.
        send(8'hA5, 16);
        check_flags("long_pulse");
        pop_check("long_pulse.pop");
        tick();
        check("long_pulse.strobe_end", rd_valid, 1'b0);
        check_flags("long_pulse.after");
        pop_check("empty_read");

        // Nine pulses into an eight-entry FIFO.
        for (int i = 1; i <= 9; i++) send(8'(i), 1 + int'($urandom % 4));
        check_flags("overflow");
        for (int i = 0; i < 8; i++) pop_check($sformatf("overflow.pop%0d", i));
        check_flags("overflow.drained");
        do_clr();
        check_flags("clr1");

        // Full FIFO, pop coincident with a new done edge.
        for (int i = 0; i < DEPTH; i++) send(8'($urandom), int'($urandom_range(1, 3)));
        check_flags("full_again");
        rx_data_in = 8'h55;
        rx_done_in = 1'b1;
        rd_en      = 1'b1;
        tick();
        rd_en = 1'b0;
        exp = q.pop_front();
        check("coincide.valid", rd_valid, 1'b1);
        check("coincide.data", rd_data, exp);
        last_rd = exp;
        model_push(8'h55, 1'b1);
        repeat (3) tick();
        rx_done_in = 1'b0;
        tick();
        check_flags("coincide");
        for (int i = 0; i < DEPTH; i++) pop_check($sformatf("coincide.pop%0d", i));
        check("coincide.last", rd_data, 8'h55);

        // Overrun set and stat_clr in the same cycle: set wins.
        for (int i = 0; i < DEPTH; i++) send(8'($urandom), 1);
        rx_data_in = 8'h3C;
        rx_done_in = 1'b1;
        stat_clr   = 1'b1;
        tick();
        stat_clr = 1'b0;
        model_err = 0;
        model_ov  = 1'b0;
        model_push(8'h3C, 1'b0);
        rx_done_in = 1'b0;
        tick();
        check_flags("ov_vs_clr");
        for (int i = 0; i < DEPTH; i++) pop_check($sformatf("ov_vs_clr.pop%0d", i));

        // Error handling and recovery timing.
        error_event("err1", 1'b0, 1'b0);
        check_flags("err1");
        for (int i = 0; i < 256; i++) error_event($sformatf("err_sat%0d", i), 1'b0, 1'b0);
        check_flags("err_sat");
        error_event("err_clr", 1'b1, 1'b0);
        check_flags("err_clr");
        error_event("err_done", 1'b0, 1'b1);
        check_flags("err_done");

        // Drop enable part-way through recovery, then re-enable.
        send(8'h11, 2);
        send(8'h22, 1);
        rx_error_in = 1'b1;
        tick();
        rx_error_in = 1'b0;
        model_err_evt(1'b0);
        repeat (9) tick();
        ctrl_enable = 1'b0;
        tick();
        check("dis.enable", rx_enable_out, 1'b0);
        rx_data_in = 8'h99;
        rx_done_in = 1'b1;
        repeat (2) tick();
        rx_done_in = 1'b0;
        tick();
        ctrl_enable = 1'b1;
        tick();
        check("reenable.enable", rx_enable_out, 1'b1);
        check_flags("reenable");
        pop_check("reenable.pop0");
        pop_check("reenable.pop1");
        check_flags("reenable.drained");

        // Randomized mix of traffic, pops, errors and clears.
        for (int i = 0; i < 60; i++) begin
            case ($urandom % 6)
                0, 1, 2: send(8'($urandom), int'($urandom_range(1, 6)));
                3, 4:    pop_check($sformatf("rnd%0d.pop", i));
                default: begin
                    if ($urandom % 2 == 0) do_clr();
                    else error_event($sformatf("rnd%0d.err", i), 1'b0, 1'b0);
                end
            endcase
            check_flags($sformatf("rnd%0d", i));
        end

        // Fill partly, then reset mid-recovery.
        send(8'h7E, 1);
        rx_error_in = 1'b1;
        tick();
        rx_error_in = 1'b0;
        repeat (5) tick();
        rx_reset = 1'b1;
        tick();
        rx_reset = 1'b0;
        q.delete();
        model_err = 0;
        model_ov  = 1'b0;
        last_rd   = 8'h00;
        check("rst2.enable", rx_enable_out, 1'b0);
        check("rst2.rd_data", rd_data, 8'h00);
        check("rst2.rd_valid", rd_valid, 1'b0);
        check_flags("rst2");
        tick();
        check("rst2.rearmed", rx_enable_out, 1'b1);

        // Reset coincident with a done edge: nothing pushed.
        rx_data_in = 8'hC3;
        rx_done_in = 1'b1;
        rx_reset   = 1'b1;
        tick();
        rx_reset = 1'b0;
        rx_done_in = 1'b0;
        tick();
        tick();
        check_flags("rst3");
        pop_check("rst3.pop");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
